// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - single-address I2C target with input glitch filter and SCL stretching
// Lines are open-drain enables: 1 releases the wire, 0 pulls it low.
module i2c_target #(
  parameter logic [6:0] Address       = 7'h50,
  parameter int         Filter_Cycles = 4
) (
  input  logic       ipClk,
  input  logic       ipReset,
  input  logic       ipSClk,
  input  logic       ipData,
  output logic       opSClk,
  output logic       opData,
  output logic       opSelected,
  output logic       opR_nW,
  output logic [7:0] opRxData,
  output logic       opRxValid,
  input  logic       ipAck,
  output logic       opTxRequest,
  input  logic [7:0] ipTxData,
  input  logic       ipTxValid,
  output logic       opStop
);
  localparam int CntW = (Filter_Cycles > 1) ? $clog2(Filter_Cycles) : 1;

  typedef enum logic [2:0] {
    sIdle, sAddress, sAddrAck, sRxData, sRxAck, sTxLoad, sTxData, sTxAck
  } tState;

  tState state, nextState;

  // index 0 = SCL, index 1 = SDA
  logic [1:0]      lineMeta, lineSync, lineFilt, linePrev;
  logic [CntW-1:0] filtCnt [2];

  logic       sclRise, sclFall, startEvt, stopEvt;
  logic [2:0] bitCnt;
  logic       byteFull;
  logic [7:0] shiftReg;
  logic [6:0] txShift;
  logic       ackGiven, masterAck;
  logic       shifting, addrMatch;

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      lineMeta   <= 2'b11;
      lineSync   <= 2'b11;
      lineFilt   <= 2'b11;
      linePrev   <= 2'b11;
      filtCnt[0] <= '0;
      filtCnt[1] <= '0;
    end else begin
      lineMeta <= {ipData, ipSClk};
      lineSync <= lineMeta;
      linePrev <= lineFilt;
      // a level only moves after Filter_Cycles consecutive disagreeing samples
      for (int i = 0; i < 2; i++) begin
        if (lineSync[i] == lineFilt[i]) begin
          filtCnt[i] <= '0;
        end else if (filtCnt[i] == CntW'(Filter_Cycles - 1)) begin
          lineFilt[i] <= lineSync[i];
          filtCnt[i]  <= '0;
        end else begin
          filtCnt[i] <= filtCnt[i] + CntW'(1);
        end
      end
    end
  end

  assign sclRise   = lineFilt[0] & ~linePrev[0];
  assign sclFall   = ~lineFilt[0] & linePrev[0];
  assign startEvt  = linePrev[1] & ~lineFilt[1] & lineFilt[0] & linePrev[0];
  assign stopEvt   = ~linePrev[1] & lineFilt[1] & lineFilt[0] & linePrev[0];
  assign shifting  = (state == sAddress) || (state == sRxData) || (state == sTxData);
  assign addrMatch = (shiftReg[7:1] == Address);

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      state <= sIdle;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    if (startEvt) begin
      nextState = sAddress;
    end else if (stopEvt) begin
      nextState = sIdle;
    end else begin
      case (state)
        sAddress: if (sclFall && byteFull) nextState = addrMatch ? sAddrAck : sIdle;
        sAddrAck: if (sclFall) nextState = opR_nW ? sTxLoad : sRxData;
        sRxData:  if (sclFall && byteFull) nextState = sRxAck;
        sRxAck:   if (sclFall) nextState = ackGiven ? sRxData : sIdle;
        sTxLoad:  if (ipTxValid) nextState = sTxData;
        sTxData:  if (sclFall && byteFull) nextState = sTxAck;
        sTxAck:   if (sclFall) nextState = masterAck ? sTxLoad : sIdle;
        default:  nextState = state;
      endcase
    end
  end

  always_comb begin
    opSClk      = 1'b1;
    opTxRequest = 1'b0;
    opStop      = stopEvt;
    if (state == sTxLoad) opSClk = 1'b0;
    if ((nextState == sTxLoad) && (state != sTxLoad)) opTxRequest = 1'b1;
  end

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      opData     <= 1'b1;
      opSelected <= 1'b0;
      opR_nW     <= 1'b0;
      opRxData   <= 8'h00;
      opRxValid  <= 1'b0;
      bitCnt     <= 3'd0;
      byteFull   <= 1'b0;
      shiftReg   <= 8'h00;
      txShift    <= 7'h00;
      ackGiven   <= 1'b0;
      masterAck  <= 1'b0;
    end else begin
      opRxValid <= 1'b0;
      if (startEvt || stopEvt) begin
        opData     <= 1'b1;
        opSelected <= 1'b0;
        bitCnt     <= 3'd0;
        byteFull   <= 1'b0;
      end else begin
        if (sclRise) begin
          shiftReg <= {shiftReg[6:0], lineFilt[1]};
          if (shifting) begin
            bitCnt <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) byteFull <= 1'b1;
          end
          if (state == sTxAck) masterAck <= ~lineFilt[1];
        end
        // local logic answers in the cycle opRxValid is shown; SCL is still low
        if (opRxValid) begin
          opData   <= ~ipAck;
          ackGiven <= ipAck;
        end
        case (state)
          sAddress: if (sclFall && byteFull) begin
            byteFull <= 1'b0;
            if (addrMatch) begin
              opData <= 1'b0;
              opR_nW <= shiftReg[0];
            end
          end
          sAddrAck: if (sclFall) begin
            opSelected <= 1'b1;
            opData     <= 1'b1;
          end
          sRxData: if (sclFall && byteFull) begin
            byteFull  <= 1'b0;
            opRxData  <= shiftReg;
            opRxValid <= 1'b1;
          end
          sRxAck: if (sclFall) opData <= 1'b1;
          sTxLoad: if (ipTxValid) begin
            txShift <= ipTxData[6:0];
            opData  <= ipTxData[7];
          end
          sTxData: if (sclFall) begin
            if (byteFull) begin
              byteFull <= 1'b0;
              opData   <= 1'b1;
            end else begin
              txShift <= {txShift[5:0], 1'b0};
              opData  <= txShift[6];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - bit-banged I2C master bench for i2c_target
// Expected acks and bytes come from the bus rules applied to each transaction.
module tb_i2c_target;
  localparam int Q = 12;

  logic ipClk = 1'b0;
  logic ipReset = 1'b1;
  logic mScl = 1'b1, mSda = 1'b1, glitch = 1'b0;
  logic ipAck = 1'b1, ipTxValid = 1'b0;
  logic [7:0] ipTxData = 8'h00;
  logic opSClk, opData, opSelected, opR_nW, opRxValid, opTxRequest, opStop;
  logic [7:0] opRxData;
  logic sclPin, sdaPin, ipSClk, ipData;

  assign sclPin = mScl & opSClk;
  assign sdaPin = mSda & opData;
  assign ipSClk = sclPin & ~glitch;
  assign ipData = sdaPin;

  i2c_target #(.Address(7'h50), .Filter_Cycles(4)) dut (
    .ipClk(ipClk), .ipReset(ipReset), .ipSClk(ipSClk), .ipData(ipData),
    .opSClk(opSClk), .opData(opData), .opSelected(opSelected), .opR_nW(opR_nW),
    .opRxData(opRxData), .opRxValid(opRxValid), .ipAck(ipAck),
    .opTxRequest(opTxRequest), .ipTxData(ipTxData), .ipTxValid(ipTxValid),
    .opStop(opStop)
  );

  always #5 ipClk = ~ipClk;

  int checks = 0, failures = 0;
  int rxCnt = 0, stopCnt = 0, txReqCnt = 0, lowRun = 0, lowMax = 0;
  bit sdaLowSeen = 1'b0;
  logic [7:0] rxQ [$];
  logic [7:0] txBytes [$];
  int txIdx = 0, txDelay = 1;
  logic [7:0] wBytes [$];
  bit wAcks [$];

  task automatic tick();
    @(negedge ipClk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic waitScl();
    int n = 0;
    while (!sclPin && n < 5000) begin
      tick();
      n++;
    end
    check("scl_release", sclPin, 1'b1);
  endtask

  task automatic mBit(input logic b, input bit g, output logic rd);
    mSda = b;
    repeat (Q) tick();
    mScl = 1'b1;
    waitScl();
    if (g) begin
      repeat (Q / 2) tick();
      glitch = 1'b1;
      repeat (2) tick();
      glitch = 1'b0;
      repeat (Q / 2) tick();
    end else begin
      repeat (Q) tick();
    end
    rd = sdaPin;
    repeat (Q) tick();
    mScl = 1'b0;
    repeat (Q) tick();
  endtask

  task automatic mByteW(input logic [7:0] d, input int gBit, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) mBit(d[i], i == gBit, r);
    mBit(1'b1, 1'b0, ack);
  endtask

  task automatic mByteR(input bit ackIt, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      mBit(1'b1, 1'b0, r);
      d[i] = r;
    end
    mBit(ackIt ? 1'b0 : 1'b1, 1'b0, r);
  endtask

  task automatic mStart();
    mSda = 1'b1;
    repeat (Q) tick();
    mScl = 1'b1;
    waitScl();
    repeat (Q) tick();
    mSda = 1'b0;
    repeat (Q) tick();
    mScl = 1'b0;
    repeat (Q) tick();
  endtask

  task automatic mStop();
    mSda = 1'b0;
    repeat (Q) tick();
    mScl = 1'b1;
    waitScl();
    repeat (Q) tick();
    mSda = 1'b1;
    repeat (2 * Q) tick();
  endtask

  task automatic doWrite(input string tag, input logic [7:0] addrByte, input bit withStop,
                         input int gBit);
    logic a;
    logic exp;
    bit match, stopped;
    logic [7:0] expQ [$];
    int rx0, st0;
    rx0 = rxCnt;
    st0 = stopCnt;
    sdaLowSeen = 1'b0;
    rxQ.delete();
    match = (addrByte[7:1] == 7'h50) && (addrByte[0] == 1'b0);
    mStart();
    mByteW(addrByte, -1, a);
    check({tag, " addr_ack"}, a, match ? 1'b0 : 1'b1);
    check({tag, " selected"}, opSelected, match);
    if (match) check({tag, " r_nw"}, opR_nW, 1'b0);
    stopped = !match;
    for (int k = 0; k < wBytes.size(); k++) begin
      ipAck = wAcks[k];
      mByteW(wBytes[k], (k == 0) ? gBit : -1, a);
      if (stopped) begin
        exp = 1'b1;
      end else begin
        expQ.push_back(wBytes[k]);
        exp = wAcks[k] ? 1'b0 : 1'b1;
        stopped = !wAcks[k];
      end
      check({tag, " data_ack"}, a, exp);
    end
    ipAck = 1'b1;
    if (withStop) begin
      mStop();
      check({tag, " stop_pulses"}, stopCnt - st0, 1);
      check({tag, " selected_after_stop"}, opSelected, 1'b0);
    end
    check({tag, " rx_count"}, rxCnt - rx0, expQ.size());
    for (int i = 0; i < expQ.size(); i++)
      check({tag, " rx_byte"}, (i < rxQ.size()) ? {24'h0, rxQ[i]} : 32'hxxxxxxxx, expQ[i]);
    if (!match) check({tag, " sda_never_low"}, sdaLowSeen, 1'b0);
  endtask

  task automatic doRead(input string tag, input int n, input bit withStop);
    logic a;
    logic [7:0] d;
    int req0;
    req0 = txReqCnt;
    txIdx = 0;
    lowMax = 0;
    mStart();
    mByteW(8'hA1, -1, a);
    check({tag, " addr_ack"}, a, 1'b0);
    check({tag, " r_nw"}, opR_nW, 1'b1);
    check({tag, " selected"}, opSelected, 1'b1);
    for (int k = 0; k < n; k++) begin
      mByteR(k != n - 1, d);
      check({tag, " rd_byte"}, d, txBytes[k]);
    end
    check({tag, " tx_requests"}, txReqCnt - req0, n);
    check({tag, " stretch_len"}, lowMax, txDelay);
    check({tag, " sda_released"}, opData, 1'b1);
    if (withStop) begin
      mStop();
      check({tag, " selected_after_stop"}, opSelected, 1'b0);
    end
  endtask

  initial forever begin
    tick();
    if (opRxValid) begin
      rxCnt++;
      rxQ.push_back(opRxData);
    end
    if (opStop) stopCnt++;
    if (opTxRequest) txReqCnt++;
    if (!opData) sdaLowSeen = 1'b1;
    if (!opSClk) begin
      lowRun++;
      if (lowRun > lowMax) lowMax = lowRun;
    end else begin
      lowRun = 0;
    end
  end

  initial forever begin
    tick();
    if (opTxRequest) begin
      repeat (txDelay) tick();
      ipTxData = (txIdx < txBytes.size()) ? txBytes[txIdx] : 8'hFF;
      txIdx++;
      ipTxValid = 1'b1;
      tick();
      ipTxValid = 1'b0;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] addrV;
    logic [6:0] r7;
    logic r;
    int st0, n;

    repeat (3) tick();
    check("rst opSClk", opSClk, 1'b1);
    check("rst opData", opData, 1'b1);
    check("rst opSelected", opSelected, 1'b0);
    check("rst opR_nW", opR_nW, 1'b0);
    check("rst opRxData", opRxData, 8'h00);
    check("rst opRxValid", opRxValid, 1'b0);
    check("rst opTxRequest", opTxRequest, 1'b0);
    check("rst opStop", opStop, 1'b0);
    ipReset = 1'b0;
    repeat (10) tick();

    wBytes = '{8'hA5}; wAcks = '{1'b1};
    doWrite("wr_a5", 8'hA0, 1'b1, -1);

    wBytes = '{8'h11}; wAcks = '{1'b1};
    doWrite("mismatch", 8'hA2, 1'b1, -1);

    txBytes = '{8'h3C, 8'h96}; txDelay = 50;
    doRead("rd_stretch", 2, 1'b1);

    wBytes = '{8'h77, 8'h12}; wAcks = '{1'b0, 1'b1};
    doWrite("data_nack", 8'hA0, 1'b1, -1);

    st0 = stopCnt;
    wBytes = '{8'h01}; wAcks = '{1'b1};
    doWrite("rs_wr", 8'hA0, 1'b0, -1);
    txBytes = '{8'h5A}; txDelay = 5;
    doRead("rs_rd", 1, 1'b0);
    check("rs no_stop_between", stopCnt - st0, 0);
    mStop();

    wBytes = '{8'hC3, 8'h5E}; wAcks = '{1'b1, 1'b1};
    doWrite("glitch", 8'hA0, 1'b1, 4);

    for (int t = 0; t < 5; t++) begin
      if ($urandom_range(0, 9) < 7) begin
        addrV = 8'hA0;
      end else begin
        r7 = 7'($urandom_range(0, 127));
        if (r7 == 7'h50) r7 = 7'h51;
        addrV = {r7, 1'($urandom_range(0, 1))};
      end
      wBytes.delete();
      wAcks.delete();
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        wBytes.push_back(8'($urandom_range(0, 255)));
        wAcks.push_back($urandom_range(0, 9) < 8);
      end
      doWrite("rand_wr", addrV, 1'b1, -1);
    end

    for (int t = 0; t < 3; t++) begin
      txBytes.delete();
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) txBytes.push_back(8'($urandom_range(0, 255)));
      txDelay = $urandom_range(1, 20);
      doRead("rand_rd", n, 1'b1);
    end

    addrV = 8'hA0;
    mStart();
    for (int i = 7; i >= 0; i--) mBit(addrV[i], 1'b0, r);
    mSda = 1'b1;
    repeat (Q) tick();
    check("rst_sda pre_low", opData, 1'b0);
    #2 ipReset = 1'b1;
    #1;
    check("rst_sda async opData", opData, 1'b1);
    check("rst_sda async opSClk", opSClk, 1'b1);
    tick();
    ipReset = 1'b0;
    repeat (10) tick();
    mStop();

    txBytes = '{8'hE7}; txDelay = 3000;
    mStart();
    mByteW(8'hA1, -1, r);
    check("rst_scl pre_stretch", opSClk, 1'b0);
    #2 ipReset = 1'b1;
    #1;
    check("rst_scl async opSClk", opSClk, 1'b1);
    check("rst_scl async opData", opData, 1'b1);
    tick();
    ipReset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- Single-address I2C target (slave) state machine, the bus-side counterpart of the team's I2C master.
- Samples SCL/SDA and drives both as open-drain enables, where output 1 means released and 0 means pull low.
- Delivers received bytes and requests transmit bytes over a simple byte interface to local logic.
- Stretches SCL while it waits for transmit data.

Parameters:
- Address, 7'h50, 7-bit target address matched against the first byte after START.
- Filter_Cycles, 4, number of consecutive identical synchronised samples required before a filtered SCL/SDA level changes (min 1).

Ports:
- ipClk  input  1  system clock; all logic on rising edge.
- ipReset  input  1  asynchronous, active-high reset.
- ipSClk  input  1  SCL pin level.
- ipData  input  1  SDA pin level.
- opSClk  output  1  SCL drive: 0 pulls low (stretch), 1 releases.
- opData  output  1  SDA drive: 0 pulls low, 1 releases.
- opSelected  output  1  high from address ACK until the next START/STOP.
- opR_nW  output  1  R/W bit of the matched address byte; valid while opSelected.
- opRxData  output  8  last byte written by the master.
- opRxValid  output  1  one-cycle pulse when opRxData updates.
- ipAck  input  1  1 = ACK received data bytes, 0 = NACK; sampled at the opRxValid cycle.
- opTxRequest  output  1  one-cycle pulse when a read byte is needed.
- ipTxData  input  8  byte to send to the master.
- ipTxValid  input  1  ipTxData accepted on any cycle with ipTxValid=1 while in sTxLoad.
- opStop  output  1  one-cycle pulse on a detected STOP.

Behaviour:
- Reset (async): opSClk=1, opData=1, opSelected=0, opR_nW=0, opRxData=0, opRxValid=0, opTxRequest=0, opStop=0; state sIdle, bit count 0. Reset mid-transfer releases both lines immediately.
- Input path: 2-flop synchroniser per line, then a Filter_Cycles glitch filter. Pulses shorter than Filter_Cycles clocks are ignored.
- Edge events are single-cycle flags derived from the filtered levels:
  - SCL rise / SCL fall.
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
- START in any state (repeated start included): release SDA, clear opSelected, bit count 0, go to sAddress.
- STOP in any state: release SDA and SCL, clear opSelected, pulse opStop, go to sIdle.
- Bit sampling is MSB first on each SCL rise. SDA changes only in the cycle after a filtered SCL fall.
- States:
  - sIdle: SDA/SCL released; wait for START.
  - sAddress: shift 8 bits. On the SCL fall after bit 8:
    - byte[7:1]==Address: drive SDA=0, set opR_nW=byte[0], go to sAddrAck.
    - otherwise: go to sIdle (ignore until next START).
  - sAddrAck: on the SCL fall ending the ACK clock, set opSelected=1.
    - opR_nW=0: release SDA, go to sRxData.
    - opR_nW=1: pull SCL low (opSClk=0), pulse opTxRequest, go to sTxLoad.
  - sRxData: shift 8 bits. On the SCL fall after bit 8:
    - load opRxData, pulse opRxValid.
    - drive opData=~ipAck, go to sRxAck.
  - sRxAck: on the ACK-clock SCL fall, release SDA.
    - if ACK was given: go to sRxData.
    - if NACK was given: go to sIdle, keeping opSelected until STOP/START.
  - sTxLoad: hold SCL low. On ipTxValid=1:
    - latch ipTxData, drive opData=ipTxData[7].
    - release SCL next cycle, go to sTxData.
    - opTxRequest does not repeat.
  - sTxData: on each SCL fall, drive the next bit. On the SCL fall after bit 8, release SDA and go to sTxAck.
  - sTxAck: sample the master's SDA on SCL rise. On the following SCL fall:
    - SDA=0 (ACK): pull SCL low, pulse opTxRequest, go to sTxLoad.
    - SDA=1 (NACK): go to sIdle (released).
- The block never drives SDA low while a START/STOP could be misread: SDA changes only after an SCL fall.
- Bit counter is 3 bits and wraps at 8.
- A START/STOP arriving in the same cycle as an SCL edge takes priority over that edge.

Test Plan:
- Write: START, 0xA0, 0xA5, STOP.
  - SDA pulled low on both ACK clocks.
  - opRxData=0xA5 with one opRxValid pulse.
  - opSelected=1, opR_nW=0.
  - opStop pulses once.
- Address mismatch: START, 0xA2, 0x11, STOP -> SDA never driven low, no opRxValid, opSelected stays 0.
- Read with stretch: START, 0xA1; ipTxValid with 0x3C delayed 50 clocks after opTxRequest.
  - SCL held low for the full delay.
  - master reads 0x3C.
  - master ACK -> second opTxRequest.
  - master NACK -> SDA released.
- Data NACK: ipAck=0 on write byte 0x77 -> SDA released on the ACK clock; the next byte is not captured until a new START.
- Repeated start: write 0xA0, 0x01, then START, 0xA1, read 0x5A -> opR_nW transitions 0->1, with no opStop between.
- Robustness:
  - 2-clock SCL glitch during a bit with Filter_Cycles=4 -> no bit shift.
  - ipReset asserted while SDA is driven low -> opData=1 and opSClk=1 asynchronously.
